// File: rtl/input_controller_pkg.sv
// Shared definitions for the gamepad input controller: reader FSM states,
// button indices inside the 5-bit masks and serial pad bit positions.
package input_controller_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StLatch,
    StShiftLo,
    StShiftHi,
    StUpdate
  } reader_state_e;

  localparam int unsigned NumButtons = 5;

  // Button positions inside buttons and each half of input_data.
  localparam int unsigned BtnUp     = 0;
  localparam int unsigned BtnDown   = 1;
  localparam int unsigned BtnLeft   = 2;
  localparam int unsigned BtnRight  = 3;
  localparam int unsigned BtnAttack = 4;

  // Serial bit positions in the word read from the pad.
  localparam int unsigned PadB     = 0;
  localparam int unsigned PadUp    = 4;
  localparam int unsigned PadDown  = 5;
  localparam int unsigned PadLeft  = 6;
  localparam int unsigned PadRight = 7;
  localparam int unsigned PadA     = 8;

  // Turns the active-low pad bits into an active-high button mask.
  function automatic logic [NumButtons-1:0] pad_to_mask(input logic [8:0] low);
    logic [NumButtons-1:0] m;
    m            = '0;
    m[BtnUp]     = ~low[PadUp];
    m[BtnDown]   = ~low[PadDown];
    m[BtnLeft]   = ~low[PadLeft];
    m[BtnRight]  = ~low[PadRight];
    m[BtnAttack] = ~low[PadB] | ~low[PadA];
    return m;
  endfunction

endpackage

// File: rtl/input_controller_shift_reader.sv
// gamepad_shift_reader: generates the latch strobe and shift clock for a
// serial gamepad, collects NUM_BITS samples and pulses done for one cycle.
module gamepad_shift_reader
  import input_controller_pkg::*;
#(
  parameter int unsigned CLK_DIV  = 4,
  parameter int unsigned NUM_BITS = 12
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                trigger,
  input  logic                pad_data,
  output logic                pad_latch,
  output logic                pad_clk,
  output logic [NUM_BITS-1:0] raw,
  output logic                done
);

  localparam int unsigned BitW = (NUM_BITS > 1) ? $clog2(NUM_BITS) : 1;
  localparam logic [3:0]      HalfLast = 4'(CLK_DIV - 1);
  localparam logic [BitW-1:0] BitLast  = BitW'(NUM_BITS - 1);

  reader_state_e       state_q, state_d;
  logic [3:0]          half_q, half_d;
  logic [BitW-1:0]     bit_q, bit_d;
  logic [NUM_BITS-1:0] raw_q, raw_d;
  logic                pad_latch_q, pad_clk_q;

  // Next-state logic: every timed state lasts CLK_DIV cycles via half_q.
  always_comb begin
    state_d = state_q;
    half_d  = half_q;
    bit_d   = bit_q;
    raw_d   = raw_q;
    unique case (state_q)
      StIdle: begin
        if (trigger) begin
          state_d = StLatch;
          half_d  = '0;
          bit_d   = '0;
        end
      end
      StLatch: begin
        if (half_q == HalfLast) begin
          state_d = StShiftLo;
          half_d  = '0;
        end else begin
          half_d = half_q + 4'd1;
        end
      end
      StShiftLo: begin
        if (half_q == HalfLast) begin
          raw_d[bit_q] = pad_data;
          state_d      = StShiftHi;
          half_d       = '0;
        end else begin
          half_d = half_q + 4'd1;
        end
      end
      StShiftHi: begin
        if (half_q == HalfLast) begin
          half_d = '0;
          if (bit_q == BitLast) begin
            state_d = StUpdate;
            bit_d   = '0;
          end else begin
            state_d = StShiftLo;
            bit_d   = bit_q + BitW'(1);
          end
        end else begin
          half_d = half_q + 4'd1;
        end
      end
      StUpdate: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // State registers; pad strobes are registered from the next state so they
  // line up with the state they belong to and never glitch.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      half_q      <= '0;
      bit_q       <= '0;
      raw_q       <= '0;
      pad_latch_q <= 1'b0;
      pad_clk_q   <= 1'b1;
    end else begin
      state_q     <= state_d;
      half_q      <= half_d;
      bit_q       <= bit_d;
      raw_q       <= raw_d;
      pad_latch_q <= (state_d == StLatch);
      pad_clk_q   <= (state_d != StShiftLo);
    end
  end

  assign pad_latch = pad_latch_q;
  assign pad_clk   = pad_clk_q;
  assign raw       = raw_q;
  assign done      = (state_q == StUpdate);

endmodule

// File: rtl/input_controller.sv
// input_controller: polls a serial gamepad on each trigger, maps the raw
// bits to five buttons, debounces across two polls and emits edge events.
module input_controller
  import input_controller_pkg::*;
#(
  parameter int unsigned CLK_DIV  = 4,
  parameter int unsigned NUM_BITS = 12
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       trigger,
  input  logic       pad_data,
  output logic       pad_latch,
  output logic       pad_clk,
  output logic [9:0] input_data,
  output logic [4:0] buttons,
  output logic       pad_present
);

  logic [NUM_BITS-1:0]   raw;
  logic                  done;
  logic                  no_pad;
  logic [NumButtons-1:0] mask, agree, buttons_new;

  logic [NumButtons-1:0] buttons_q, prev_q;
  logic [9:0]            input_data_q;
  logic                  pad_present_q;

  gamepad_shift_reader #(
    .CLK_DIV  (CLK_DIV),
    .NUM_BITS (NUM_BITS)
  ) u_reader (
    .clk       (clk),
    .reset     (reset),
    .trigger   (trigger),
    .pad_data  (pad_data),
    .pad_latch (pad_latch),
    .pad_clk   (pad_clk),
    .raw       (raw),
    .done      (done)
  );

  // Map the poll result; a bit only takes effect when two polls agree.
  always_comb begin
    no_pad      = (raw == '0);
    mask        = no_pad ? '0 : pad_to_mask(raw[8:0]);
    agree       = ~(mask ^ prev_q);
    buttons_new = (agree & mask) | (~agree & buttons_q);
  end

  // Commit the poll on done; input_data is a single-cycle event word.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      buttons_q     <= '0;
      prev_q        <= '0;
      input_data_q  <= '0;
      pad_present_q <= 1'b0;
    end else begin
      input_data_q <= '0;
      if (done) begin
        buttons_q     <= buttons_new;
        prev_q        <= mask;
        pad_present_q <= ~no_pad;
        input_data_q  <= {buttons_new & ~buttons_q, buttons_q & ~buttons_new};
      end
    end
  end

  assign input_data  = input_data_q;
  assign buttons     = buttons_q;
  assign pad_present = pad_present_q;

endmodule

// File: tb/tb_input_controller.sv
// Scoreboard bench for input_controller: a behavioural pad drives serial
// data, each poll's expected event is queued and a monitor checks it.
module tb_input_controller;

  localparam int unsigned CD = 4;
  localparam int unsigned NB = 12;
  localparam int unsigned PollLen = (1 + 2 * NB) * CD;

  typedef struct packed {
    logic [9:0]  data;
    logic [4:0]  btn;
    logic        present;
    int unsigned cyc;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       trigger = 1'b0;
  logic       pad_data;
  logic       pad_latch, pad_clk;
  logic [9:0] input_data;
  logic [4:0] buttons;
  logic       pad_present;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  int unsigned cyc = 0;

  exp_t exp_q[$];

  // Reference state: held buttons, previous raw mask, pad presence.
  logic [4:0] m_btn = '0;
  logic [4:0] m_prev = '0;
  logic       m_present = 1'b0;

  // Pad model: active-low word; latch selects bit 0, each rising clock advances.
  logic [NB-1:0] pad_word = '1;
  int            pad_idx = 0;

  input_controller #(
    .CLK_DIV  (CD),
    .NUM_BITS (NB)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .trigger     (trigger),
    .pad_data    (pad_data),
    .pad_latch   (pad_latch),
    .pad_clk     (pad_clk),
    .input_data  (input_data),
    .buttons     (buttons),
    .pad_present (pad_present)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge pad_latch or posedge pad_clk) begin
    if (pad_latch) pad_idx = 0;
    else pad_idx = pad_idx + 1;
  end

  always_comb begin
    if (pad_idx < NB) pad_data = pad_word[pad_idx];
    else pad_data = pad_word[NB-1];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Reference behaviour of one complete poll of word w.
  task automatic model_poll(input logic [NB-1:0] w, output logic [9:0] ev);
    logic [4:0] pressed, next_btn;
    if (w == '0) begin
      m_present = 1'b0;
      pressed   = '0;
    end else begin
      m_present  = 1'b1;
      pressed[0] = !w[4];
      pressed[1] = !w[5];
      pressed[2] = !w[6];
      pressed[3] = !w[7];
      pressed[4] = !w[0] || !w[8];
    end
    for (int i = 0; i < 5; i++) begin
      if (pressed[i] == m_prev[i]) next_btn[i] = pressed[i];
      else next_btn[i] = m_btn[i];
    end
    ev     = {next_btn & ~m_btn, m_btn & ~next_btn};
    m_btn  = next_btn;
    m_prev = pressed;
  endtask

  // Monitor: every nonzero event word must match the head of the queue.
  always @(negedge clk) begin
    if (reset === 1'b1 && input_data !== 10'd0) begin
      if (exp_q.size() == 0) begin
        check("unexpected_event", 32'(input_data), 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("event_data", 32'(input_data), 32'(e.data));
        check("event_buttons", 32'(buttons), 32'(e.btn));
        check("event_present", 32'(pad_present), 32'(e.present));
        check("event_cycle", cyc, e.cyc);
      end
    end
  end

  // One poll; extra_trig pulses trigger mid-poll, abort_at > 0 resets then.
  task automatic run_poll(input logic [NB-1:0] w, input bit extra_trig, input int abort_at);
    int unsigned t0, latch_n, low_n, pulses;
    logic        prev_clk;
    logic [9:0]  ev;
    bit          aborted;
    pad_word = w;
    latch_n  = 0;
    low_n    = 0;
    pulses   = 0;
    prev_clk = 1'b1;
    aborted  = 1'b0;
    @(negedge clk);
    trigger = 1'b1;
    t0      = cyc + 1;
    if (abort_at == 0) begin
      model_poll(w, ev);
      if (ev != '0) exp_q.push_back('{ev, m_btn, m_present, t0 + 1 + PollLen});
    end
    @(negedge clk);
    trigger = 1'b0;
    for (int i = 0; i <= int'(PollLen) + 4; i++) begin
      if (pad_latch) latch_n++;
      if (!pad_clk) low_n++;
      if (prev_clk && !pad_clk) pulses++;
      prev_clk = pad_clk;
      if (extra_trig && i == 49) trigger = 1'b1;
      if (extra_trig && i == 50) trigger = 1'b0;
      if (abort_at != 0 && i == abort_at) begin
        reset = 1'b0;
        #1;
        check("abort_pad_clk", 32'(pad_clk), 32'd1);
        check("abort_pad_latch", 32'(pad_latch), 32'd0);
        check("abort_input_data", 32'(input_data), 32'd0);
        check("abort_buttons", 32'(buttons), 32'd0);
        @(negedge clk);
        reset     = 1'b1;
        m_btn     = '0;
        m_prev    = '0;
        m_present = 1'b0;
        aborted   = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (aborted) begin
      repeat (PollLen + 10) @(negedge clk);
      check("abort_pad_latch_idle", 32'(pad_latch), 32'd0);
    end else begin
      check("latch_cycles", latch_n, CD);
      check("clk_low_cycles", low_n, NB * CD);
      check("clk_low_pulses", pulses, NB);
      check("buttons", 32'(buttons), 32'(m_btn));
      check("pad_present", 32'(pad_present), 32'(m_present));
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [NB-1:0] w;
    repeat (3) @(negedge clk);
    check("rst_pad_latch", 32'(pad_latch), 32'd0);
    check("rst_pad_clk", 32'(pad_clk), 32'd1);
    check("rst_input_data", 32'(input_data), 32'd0);
    check("rst_buttons", 32'(buttons), 32'd0);
    check("rst_pad_present", 32'(pad_present), 32'd0);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // Right press with an ignored mid-poll trigger, then release.
    run_poll(12'hF7F, 1'b1, 0);
    run_poll(12'hF7F, 1'b0, 0);
    run_poll(12'hFFF, 1'b0, 0);
    run_poll(12'hFFF, 1'b0, 0);
    // Attack via A, then pad missing.
    run_poll(12'hEFF, 1'b0, 0);
    run_poll(12'hEFF, 1'b0, 0);
    run_poll(12'h000, 1'b0, 0);
    run_poll(12'h000, 1'b0, 0);
    // Mixed press and release in one word: hold up, then swap to down.
    run_poll(12'hFEF, 1'b0, 0);
    run_poll(12'hFEF, 1'b0, 0);
    run_poll(12'hFDF, 1'b0, 0);
    run_poll(12'hFDF, 1'b0, 0);
    // Bounce: up for a single poll.
    run_poll(12'hFFF, 1'b0, 0);
    run_poll(12'hFFF, 1'b0, 0);
    run_poll(12'hFEF, 1'b0, 0);
    run_poll(12'hFFF, 1'b0, 0);
    run_poll(12'hFFF, 1'b0, 0);
    // Mid-poll reset while right is held, then a full poll pair.
    run_poll(12'hF7F, 1'b0, 0);
    run_poll(12'hF7F, 1'b0, 0);
    run_poll(12'hFFF, 1'b0, 40);
    run_poll(12'hF7F, 1'b0, 0);
    run_poll(12'hF7F, 1'b0, 0);

    // Random polls, often repeating the previous word so debounce settles.
    w = 12'hFFF;
    for (int n = 0; n < 40; n++) begin
      int unsigned r;
      r = $urandom_range(0, 9);
      if (r == 0) w = '0;
      else if (r >= 4) begin
        w = 12'($urandom);
        if (w == '0) w = 12'h001;
      end
      run_poll(w, 1'b0, 0);
    end

    repeat (4) @(negedge clk);
    check("queue_drained", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/input_controller.md
INPUT_CONTROLLER -- requirements
Module: input_controller

Interface
REQ-001 Parameter CLK_DIV, default 4, SHALL set each pad_latch pulse and each pad_clk half-period in clk cycles (legal range 2..15).
REQ-002 Parameter NUM_BITS, default 12, SHALL set the number of serial gamepad bits read per poll.
REQ-003 clk  input  1  the single system clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 trigger  input  1  frame tick; starts one poll when sampled high in IDLE.
REQ-006 pad_data  input  1  serial gamepad data, active-low (0 = pressed).
REQ-007 pad_latch  output  1  gamepad latch strobe, active-high.
REQ-008 pad_clk  output  1  gamepad shift clock; idles high.
REQ-009 input_data  output  10  one-cycle event word: [9:5] press events, [4:0] release events, each field ordered {attack, right, left, down, up} from MSB to LSB.
REQ-010 buttons  output  5  debounced held state, same order as the input_data fields.
REQ-011 pad_present  output  1  high when the last poll did not read all NUM_BITS bits as pressed.

Function
REQ-012 FSM states SHALL be IDLE, LATCH, SHIFT_LO, SHIFT_HI and UPDATE.
REQ-013 A trigger sampled in any state other than IDLE SHALL be ignored; no queuing.
REQ-014 IDLE plus trigger SHALL enter LATCH; pad_latch SHALL be high for exactly CLK_DIV cycles, then the FSM SHALL enter SHIFT_LO.
REQ-015 SHIFT_LO SHALL drive pad_clk low for CLK_DIV cycles and sample pad_data on its last cycle into bit index k (k = 0 first).
REQ-016 SHIFT_HI SHALL drive pad_clk high for CLK_DIV cycles, then either return to SHIFT_LO (k < NUM_BITS-1) or enter UPDATE.
REQ-017 Bit map (pressed = sampled 0): bit 4 up, bit 5 down, bit 6 left, bit 7 right; attack = bit 0 (B) OR bit 8 (A); all other bits are ignored.
REQ-018 If all NUM_BITS samples are 0, the poll SHALL be treated as "no pad": pad_present = 0 and the raw mask = 00000.
REQ-019 Debounce: a raw mask bit SHALL update buttons only when it equals that bit's raw value from the previous poll (two consecutive agreeing polls).
REQ-020 UPDATE SHALL last one cycle and SHALL register the following: buttons_new; input_data[9:5] = buttons_new AND NOT buttons_old; input_data[4:0] = buttons_old AND NOT buttons_new. The FSM SHALL then return to IDLE.
REQ-021 input_data SHALL be nonzero for exactly one clk cycle per poll, and only when a change occurred; it SHALL be 0 in every other cycle.
REQ-022 Latency: with the trigger sampled at edge N, pad_latch SHALL be high over cycles N+1..N+CLK_DIV, and input_data SHALL be valid in the cycle after edge N+1+25*CLK_DIV (edge N+101 for the defaults).
REQ-023 A press and a release of different buttons in the same poll SHALL both appear in the same input_data word.
REQ-024 The shift-bit counter SHALL be ceil(log2(NUM_BITS)) wide, and the half-period counter SHALL be 4 bits wide; neither SHALL wrap within one poll.

Reset
REQ-025 With reset low: state = IDLE, pad_latch = 0, pad_clk = 1, input_data = 0, buttons = 0, pad_present = 0, the previous-raw register = 0, and all counters = 0.
REQ-026 Reset asserted mid-poll SHALL abort the poll immediately with no event emitted; the first poll after reset starts only on the next trigger.

Structure
REQ-027 A shared package SHALL hold the FSM state encodings, the button bit indices (UP = 0, DOWN = 1, LEFT = 2, RIGHT = 3, ATTACK = 4), and the pad bit positions (B = 0, UP = 4, DOWN = 5, LEFT = 6, RIGHT = 7, A = 8).
REQ-028 The serial timing (REQ-012..REQ-016) SHALL be implemented in one sub-module, gamepad_shift_reader, which outputs a NUM_BITS-wide raw word plus a one-cycle done pulse. Mapping, debounce and edge logic SHALL stay in input_controller.

Verification
REQ-029 Scenario, right press: pad model drives bit 7 = 0 (all others 1) for two polls -> poll 1 input_data = 0; poll 2 input_data = 10'b01000_00000 for one cycle; buttons = 01000.
REQ-030 Scenario, release: from right held, drive all bits 1 for two polls -> poll 2 input_data = 10'b00000_01000 and buttons = 00000.
REQ-031 Scenario, attack and no pad: A pressed -> after two polls input_data[9] = 1. Then pad_data tied 0 for two polls -> pad_present = 0 and a release event 00000_10000.
REQ-032 Scenario, timing: defaults, trigger at edge 0 -> pad_latch high over cycles 1..4; 12 pad_clk low pulses of 4 cycles each; input_data valid after edge 101. A second trigger at edge 50 is ignored.
REQ-033 Scenario, bounce: up pressed for one poll only, surrounded by released polls -> no event and buttons stays 00000.
REQ-034 Scenario, mid-poll reset: reset low at edge 40 of a poll -> pad_clk = 1, pad_latch = 0, and no input_data pulse. After release, the next trigger runs a full poll.
